// File: rtl/alu_issue_ctrl.sv
// Instruction issue controller for the 32-bit ALU: decodes R-type/ADDI words, reads operands
// from a 32x32 register file, waits out the ALU latency and writes the result back.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  output logic [3:0]  alu_cntrl_o,
  output logic [31:0] alu_rs1_o,
  output logic [31:0] alu_rs2_o,
  input  logic [31:0] alu_out_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        illegal_o,
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StIll} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  cntrl_q, cntrl_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        ready_q, ready_d;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic [3:0]  dec_cntrl;
  logic        dec_legal;
  logic        dec_imm;
  logic        accept;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign f7     = instr_i[31:25];
  assign imm    = {{20{instr_i[31]}}, instr_i[31:20]};
  assign accept = instr_valid_i & ready_q;

  always_comb begin
    dec_cntrl = 4'd0;
    dec_legal = 1'b0;
    dec_imm   = 1'b0;
    if (opcode == 7'b0110011) begin
      dec_legal = 1'b1;
      case ({f3, f7})
        {3'd0, 7'h00}: dec_cntrl = 4'd1;
        {3'd0, 7'h20}: dec_cntrl = 4'd2;
        {3'd1, 7'h00}: dec_cntrl = 4'd3;
        {3'd5, 7'h00}: dec_cntrl = 4'd4;
        {3'd5, 7'h20}: dec_cntrl = 4'd5;
        {3'd2, 7'h00}: dec_cntrl = 4'd6;
        {3'd3, 7'h00}: dec_cntrl = 4'd7;
        {3'd4, 7'h00}: dec_cntrl = 4'd8;
        {3'd6, 7'h00}: dec_cntrl = 4'd9;
        {3'd7, 7'h00}: dec_cntrl = 4'd10;
        default:       dec_legal = 1'b0;
      endcase
    end else if (opcode == 7'b0010011 && f3 == 3'd0) begin
      dec_cntrl = 4'd1;
      dec_legal = 1'b1;
      dec_imm   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    cntrl_d = cntrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_legal) begin
            state_d = StIssue;
            cntrl_d = dec_cntrl;
            rs1_d   = rf_q[rs1_f];
            rs2_d   = dec_imm ? imm : rf_q[rs2_f];
            rd_d    = rd_f;
          end else begin
            state_d = StIll;
          end
        end
      end
      StIssue: begin
        cnt_d   = 3'(ALU_LAT - 1);
        state_d = (ALU_LAT <= 1) ? StWb : StWait;
      end
      StWait: begin
        if (cnt_q <= 3'd1) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWb: begin
        state_d = StIdle;
        cntrl_d = 4'd0;
        rs1_d   = '0;
        rs2_d   = '0;
      end
      StIll:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Ready is registered, so it tracks the state we are about to enter.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
      cntrl_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      cntrl_q <= cntrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ready_q <= ready_d;
    end
  end

  // x0 is never written, so operand reads of x0 see the reset value 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (state_q == StWb && rd_q != 5'd0) begin
      rf_q[rd_q] <= alu_out_i;
    end
  end

  assign instr_ready_o = ready_q;
  assign alu_cntrl_o   = cntrl_q;
  assign alu_rs1_o     = rs1_q;
  assign alu_rs2_o     = rs2_q;
  assign wb_valid_o    = (state_q == StWb);
  assign wb_rd_o       = wb_valid_o ? rd_q : 5'd0;
  assign wb_data_o     = wb_valid_o ? alu_out_i : 32'd0;
  assign illegal_o     = (state_q == StIll);
  assign dbg_rdata_o   = (dbg_raddr_i == 5'd0) ? 32'd0 : rf_q[dbg_raddr_i];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU_LAT=1 and ALU_LAT=3 instances, behavioural ALU models and a
// writeback scoreboard filled at accept time and drained on wb_valid.
module tb_alu_issue_ctrl;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        instr_valid, instr_valid3;
  logic        instr_ready, instr_ready3;
  logic [31:0] instr, instr3;
  logic [3:0]  alu_cntrl, alu_cntrl3;
  logic [31:0] alu_rs1, alu_rs2, alu_rs13, alu_rs23;
  logic [31:0] alu_out, alu_out3;
  logic        wb_valid, wb_valid3;
  logic [4:0]  wb_rd, wb_rd3;
  logic [31:0] wb_data, wb_data3;
  logic        illegal, illegal3;
  logic [4:0]  dbg_raddr, dbg_raddr3;
  logic [31:0] dbg_rdata, dbg_rdata3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  wb_t         exp_q[$];
  logic [31:0] rm [32];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_i(instr), .alu_cntrl_o(alu_cntrl), .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2),
    .alu_out_i(alu_out), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .illegal_o(illegal), .dbg_raddr_i(dbg_raddr), .dbg_rdata_o(dbg_rdata)
  );

  alu_issue_ctrl #(.ALU_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .instr_valid_i(instr_valid3), .instr_ready_o(instr_ready3),
    .instr_i(instr3), .alu_cntrl_o(alu_cntrl3), .alu_rs1_o(alu_rs13), .alu_rs2_o(alu_rs23),
    .alu_out_i(alu_out3), .wb_valid_o(wb_valid3), .wb_rd_o(wb_rd3), .wb_data_o(wb_data3),
    .illegal_o(illegal3), .dbg_raddr_i(dbg_raddr3), .dbg_rdata_o(dbg_rdata3)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a << b[4:0];
      4'd4:    return a >> b[4:0];
      4'd5:    return $signed(a) >>> b[4:0];
      4'd6:    return {31'd0, $signed(a) < $signed(b)};
      4'd7:    return {31'd0, a < b};
      4'd8:    return a ^ b;
      4'd9:    return a | b;
      4'd10:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // Registered ALU models with the matching latency.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe1 <= '0;
    else        pipe1 <= alu_f(alu_cntrl, alu_rs1, alu_rs2);
  end
  always @(posedge clk or negedge rst3_n) begin
    if (!rst3_n) begin
      pipe3[0] <= '0; pipe3[1] <= '0; pipe3[2] <= '0;
    end else begin
      pipe3[0] <= alu_f(alu_cntrl3, alu_rs13, alu_rs23);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end
  assign alu_out  = pipe1;
  assign alu_out3 = pipe3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1 chk(tag, dbg_rdata, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
      if (wb_valid || illegal) chk("wb_ill_excl", 32'(wb_valid & illegal), 32'd0);
    end
  end

  // exp_c is the expected cntrl code for a legal word, 0 for an illegal one.
  task automatic run(input logic [31:0] w, input logic [3:0] exp_c);
    logic [31:0] a, b, r;
    int n;
    a = rm[w[19:15]];
    b = (w[6:0] == 7'b0010011) ? {{20{w[31]}}, w[31:20]} : rm[w[24:20]];
    r = alu_f(exp_c, a, b);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    if (exp_c != 4'd0) begin
      exp_q.push_back({w[11:7], r});
      if (w[11:7] != 5'd0) rm[w[11:7]] = r;
    end
    @(negedge clk);
    chk("issue_cntrl", 32'(alu_cntrl), 32'(exp_c));
    chk("busy_ready", 32'(instr_ready), 32'd0);
    if (exp_c != 4'd0) begin
      chk("issue_rs1", alu_rs1, a);
      chk("issue_rs2", alu_rs2, b);
      n = 1;
      while (!wb_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("wb_latency", 32'(n), 32'(LAT + 1));
      @(negedge clk);
    end else begin
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_no_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("ill_one_cycle", 32'(illegal), 32'd0);
      chk("ill_ready_back", 32'(instr_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    logic r;
    for (int i = 0; i < 32; i++) rm[i] = '0;
    rst_n = 1'b0; rst3_n = 1'b0;
    instr_valid = 1'b0; instr_valid3 = 1'b0;
    instr = '0; instr3 = '0;
    dbg_raddr = '0; dbg_raddr3 = '0;
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_cntrl", 32'(alu_cntrl), 32'd0);
    chk("rst_rs1", alu_rs1, 32'd0);
    chk("rst_rs2", alu_rs2, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_low_at_release", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(instr_ready), 32'd1);

    run(addi(5'd1, 5'd0, 12'd5), 4'd1);
    run(addi(5'd2, 5'd0, 12'hFFD), 4'd1);
    dbg_chk("x1_is_5", 5'd1, 32'd5);
    dbg_chk("x2_is_m3", 5'd2, 32'hFFFF_FFFD);

    run(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 4'd2);
    run(rtype(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), 4'd6);
    run(rtype(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), 4'd7);
    run(rtype(7'h20, 5'd1, 5'd2, 3'd5, 5'd6), 4'd5);
    run(rtype(7'h00, 5'd1, 5'd1, 3'd1, 5'd8), 4'd3);
    run(rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd9), 4'd8);
    dbg_chk("sub_x3", 5'd3, 32'd8);
    dbg_chk("slt_x4", 5'd4, 32'd1);
    dbg_chk("sltu_x5", 5'd5, 32'd0);
    dbg_chk("sra_x6", 5'd6, 32'hFFFF_FFFF);
    dbg_chk("sll_x8", 5'd8, 32'd160);

    // Back-to-back dependent pair with instr_valid held high.
    @(negedge clk);
    instr = addi(5'd7, 5'd0, 12'd1);
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    exp_q.push_back({5'd7, 32'd1});
    rm[7] = 32'd1;
    @(negedge clk);
    instr = rtype(7'h00, 5'd7, 5'd7, 3'd0, 5'd7);
    n = 1;
    @(posedge clk);
    r = 1'b0;
    while (!r && n < 20) begin
      @(negedge clk);
      r = instr_ready;
      @(posedge clk);
      n++;
    end
    #1 instr_valid = 1'b0;
    chk("b2b_accept_gap", 32'(n), 32'd3);
    exp_q.push_back({5'd7, 32'd2});
    rm[7] = 32'd2;
    repeat (4) @(negedge clk);
    dbg_chk("b2b_x7", 5'd7, 32'd2);

    run(32'h0000_007F, 4'd0);
    for (int i = 0; i < 10; i++) dbg_chk("rf_unchanged", 5'(i), rm[i]);

    run(addi(5'd0, 5'd0, 12'd9), 4'd1);
    dbg_chk("x0_stays_0", 5'd0, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // ALU_LAT=3 instance: latency and reset during WAIT.
    @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    chk("l3_ready", 32'(instr_ready3), 32'd1);
    instr3 = addi(5'd1, 5'd0, 12'd7);
    instr_valid3 = 1'b1;
    @(posedge clk);
    #1 instr_valid3 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_valid3 && n < 20);
    chk("l3_latency", 32'(n), 32'd4);
    chk("l3_wb_rd", 32'(wb_rd3), 32'd1);
    chk("l3_wb_data", wb_data3, 32'd7);
    @(negedge clk);
    dbg_raddr3 = 5'd1;
    #1 chk("l3_x1", dbg_rdata3, 32'd7);
    chk("l3_ready_again", 32'(instr_ready3), 32'd1);
    instr3 = addi(5'd2, 5'd0, 12'd5);
    instr_valid3 = 1'b1;
    @(posedge clk);
    #1 instr_valid3 = 1'b0;
    repeat (2) @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("l3_rst_ready", 32'(instr_ready3), 32'd0);
    chk("l3_rst_cntrl", 32'(alu_cntrl3), 32'd0);
    chk("l3_rst_rs1", alu_rs13, 32'd0);
    chk("l3_rst_rs2", alu_rs23, 32'd0);
    chk("l3_rst_wb_valid", 32'(wb_valid3), 32'd0);
    chk("l3_rst_wb_data", wb_data3, 32'd0);
    chk("l3_rst_illegal", 32'(illegal3), 32'd0);
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    #1 chk("l3_ready_at_release", 32'(instr_ready3), 32'd0);
    @(negedge clk);
    chk("l3_ready_after_release", 32'(instr_ready3), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("l3_no_wb_after_rst", 32'(wb_valid3), 32'd0);
      @(negedge clk);
    end
    dbg_raddr3 = 5'd2;
    #1 chk("l3_x2_not_written", dbg_rdata3, 32'd0);
    dbg_raddr3 = 5'd1;
    #1 chk("l3_x1_cleared", dbg_rdata3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction-side counterpart of the 32-bit ALU: accepts one R-type or ADDI instruction word per handshake and decodes it.
- Reads operands from an internal 32x32 register file and drives the ALU's cntrl/rs1/rs2 inputs.
- Waits out the ALU's registered latency, captures the ALU result and writes it back to rd.
- Sits between the instruction source and the ALU in the core datapath.

Parameters:
- ALU_LAT, 1, clock edges from the ALU inputs being driven to ALU out being valid (legal 1..4).

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word offered.
- instr_ready  out  1  controller can accept a new instruction.
- instr  in  32  instruction word, RISC-V field layout.
- alu_cntrl  out  4  ALU operation code.
- alu_rs1  out  32  ALU operand A.
- alu_rs2  out  32  ALU operand B.
- alu_out  in  32  ALU result (registered inside the ALU).
- wb_valid  out  1  one-cycle pulse when a result is written back.
- wb_rd  out  5  destination register of that writeback.
- wb_data  out  32  data written.
- illegal  out  1  one-cycle pulse for an undecodable instruction.
- dbg_raddr  in  5  debug read address.
- dbg_rdata  out  32  combinational register-file read; x0 always reads 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all 32 registers clear to 0.
  - instr_ready, wb_valid and illegal go to 0.
  - alu_cntrl, alu_rs1, alu_rs2, wb_rd and wb_data go to 0.
  - An instruction in flight is abandoned with no writeback.
- instr_ready is registered:
  - 1 only in IDLE, first asserted the cycle after reset release.
  - Accept happens when instr_valid and instr_ready are both 1 on a clock edge.
- Decode at accept (opcode=instr[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7=[31:25]):
  - opcode 0110011 (R-type), mapping (f3,f7) to cntrl:
    - (0,00)->1 ADD; (0,20)->2 SUB
    - (1,00)->3 SLL; (5,00)->4 SRL; (5,20)->5 SRA
    - (2,00)->6 SLT; (3,00)->7 SLTU
    - (4,00)->8 XOR; (6,00)->9 OR; (7,00)->A AND
  - opcode 0010011 with f3=0 (ADDI): cntrl 1; alu_rs2 = sign-extended instr[31:20].
  - Anything else is illegal.
- State machine:
  - IDLE -> ISSUE on a legal accept. alu_cntrl, alu_rs1 = R[rs1], alu_rs2 = R[rs2] or imm are loaded on the accept edge. Register reads use the file contents at that edge.
  - IDLE -> ILL on an illegal accept. illegal=1 for exactly one cycle; alu_cntrl stays 0; no register changes. ILL -> IDLE.
  - ISSUE lasts 1 cycle. If ALU_LAT=1, ISSUE -> WB; otherwise ISSUE -> WAIT, with a counter loaded to ALU_LAT-1.
  - WAIT decrements the counter and goes to WB when it reaches 1.
  - WB (alu_out valid in this cycle): wb_valid=1, wb_rd=rd, wb_data=alu_out, and R[rd] is written on the edge ending WB. WB -> IDLE.
- alu_cntrl/alu_rs1/alu_rs2 hold their values from ISSUE through WB, then return to 0 in IDLE.
  - cntrl 0 selects the ALU default; its output is ignored outside WB.
- x0 handling: a write with rd=0 still pulses wb_valid with wb_rd=0, but R[0] stays 0.
- Throughput: one instruction per ALU_LAT+2 cycles. Back-to-back dependent instructions need no forwarding, because the write completes before the return to IDLE.
- wb_valid and illegal are never high in the same cycle.

Test Plan:
- Reset, then ADDI x1,x0,5 followed by ADDI x2,x0,-3:
  - ISSUE cycle shows alu_cntrl=1, alu_rs2=0xFFFFFFFD.
  - WB pulses wb_rd=2, wb_data=0xFFFFFFFD (ALU model).
  - dbg_rdata at x1 reads 5.
- With x1=5, x2=-3:
  - SUB x3,x1,x2 -> alu_cntrl=2, wb_data=8.
  - SLT x4,x2,x1 -> 1; SLTU x5,x2,x1 -> 0.
  - SRA x6,x2,x1 -> 0xFFFFFFFF.
  - wb_valid exactly ALU_LAT+1 cycles after accept.
- Back-to-back dependency: ADDI x7,x0,1 then ADD x7,x7,x7 with instr_valid held high.
  - Second accept occurs 3 cycles after the first.
  - Final x7=2.
- Illegal word 0x0000007F:
  - illegal pulses 1 cycle; no wb_valid.
  - instr_ready back to 1 two cycles after accept; register file unchanged.
- ADDI x0,x0,9: wb_valid=1, wb_rd=0, dbg_rdata at x0 stays 0.
- ALU_LAT=3 build: wb_valid 4 cycles after accept. rst_n pulled low during WAIT: outputs 0 immediately, target register not written, instr_ready returns to 1 one cycle after release.
